// File: rtl/aes_arb_pkg.sv
// Shared types and widths for the AES core arbiter.
// Used by aes_rr_pick and aes_core_arbiter.
package aes_arb_pkg;
    localparam int AES_BLK_W = 128;
    localparam int GRANT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;
endpackage

// File: rtl/aes_rr_pick.sv
// Combinational rotating-priority picker.
// Scans from last_grant+1 upward, wrapping at NREQ.
import aes_arb_pkg::*;

module aes_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [NREQ-1:0]    pick_oh,
    output logic [GRANT_W-1:0] pick_idx,
    output logic               any
);

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] &&
                    (i == (int'(last_grant) + k) % NREQ)) begin
                    any        = 1'b1;
                    pick_oh[i] = 1'b1;
                    pick_idx   = i[GRANT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES encrypt core among NREQ requesters.
// Define AES_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
import aes_arb_pkg::*;

module aes_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      vclk,
    input  logic                      vrst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AES_BLK_W-1:0] req_key,
    input  logic [NREQ*AES_BLK_W-1:0] req_text,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [AES_BLK_W-1:0]      rsp_data,
    output logic                      rsp_err,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy,
    output logic                      core_ld,
    output logic [AES_BLK_W-1:0]      core_key,
    output logic [AES_BLK_W-1:0]      core_text,
    input  logic                      core_done,
    input  logic [AES_BLK_W-1:0]      core_text_out
);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("aes_core_arbiter: NREQ must be 2..8, TIMEOUT >= 2");
    end

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_q, last_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] text_q, text_d;
    logic [AES_BLK_W-1:0] data_q, data_d;

    logic [NREQ-1:0]      pick_oh;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;

    aes_rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .any        (pick_any)
    );

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            to_hit;

    assign to_hit = (cnt_q == TO_W'(TIMEOUT - 1));

    // Counter idles at zero so it is clear on every entry to WAIT.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (core_done)   err_d = 1'b0;
            else if (to_hit) err_d = 1'b1;
        end
    end

    always_ff @(posedge vclk) begin
        if (vrst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        key_d     = key_q;
        text_d    = text_q;
        data_d    = data_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_oh;
                    grant_d   = pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_oh[i]) begin
                            key_d  = req_key[i*AES_BLK_W +: AES_BLK_W];
                            text_d = req_text[i*AES_BLK_W +: AES_BLK_W];
                        end
                    end
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    data_d  = core_text_out;
                    state_d = ST_RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    data_d  = '0;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    rsp_valid[i] = (grant_q == i[GRANT_W-1:0]);
                end
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge vclk) begin
        if (vrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GRANT_W'(NREQ - 1);
            key_q   <= '0;
            text_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            key_q   <= key_d;
            text_q  <= text_d;
            data_q  <= data_d;
        end
    end

    assign rsp_data  = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign core_ld   = (state_q == ST_LOAD);
    assign core_key  = key_q;
    assign core_text = text_q;

endmodule
